// File: rtl/pc_thread_fifo.sv
// pc_thread_fifo: show-ahead circular FIFO of (pc, cc_id) thread tokens with per-cc_id occupancy tracking.
//   clk, rst                   : clock, asynchronous active-high reset
//   in_pc_valid/in_pc/in_cc_id : producer token offer; in_pc_ready = !full
//   out_pc_valid/out_pc/...    : head token (zero when empty); out_pc_ready pops it
//   cc_id_empty                : bit i set when no stored token carries cc_id i
//   occupancy, full, empty     : fill level and its extremes
module pc_thread_fifo #(
    parameter int PC_WIDTH   = 9,
    parameter int CC_ID_BITS = 2,
    parameter int DEPTH      = 16,
    localparam int AW  = $clog2(DEPTH),
    localparam int OW  = $clog2(DEPTH + 1),
    localparam int NCC = 2 ** CC_ID_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_pc_valid,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [CC_ID_BITS-1:0] in_cc_id,
    output logic                  in_pc_ready,
    output logic                  out_pc_valid,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [CC_ID_BITS-1:0] out_cc_id,
    input  logic                  out_pc_ready,
    output logic [NCC-1:0]        cc_id_empty,
    output logic [OW-1:0]         occupancy,
    output logic                  full,
    output logic                  empty
);
    logic [PC_WIDTH-1:0]   pc_mem_q [DEPTH];
    logic [CC_ID_BITS-1:0] cc_mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d, cnt_sum;
    logic [OW-1:0]         cnt_q [NCC];
    logic [OW-1:0]         cnt_d [NCC];
    logic                  push, pop;

    assign full         = occ_q == OW'(DEPTH);
    assign empty        = occ_q == '0;
    assign occupancy    = occ_q;
    assign in_pc_ready  = !full;
    assign out_pc_valid = !empty;
    assign out_pc       = empty ? '0 : pc_mem_q[rd_ptr_q];
    assign out_cc_id    = empty ? '0 : cc_mem_q[rd_ptr_q];
    assign push         = in_pc_valid && !full;
    assign pop          = !empty && out_pc_ready;

    genvar g;
    for (g = 0; g < NCC; g++) begin : g_cc_empty
        assign cc_id_empty[g] = cnt_q[g] == '0;
    end

    // A push and pop on the same cc_id cancel out in that slot's counter.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d    = occ_q + OW'(push) - OW'(pop);
        cnt_sum  = '0;
        for (int i = 0; i < NCC; i++) begin
            cnt_d[i] = cnt_q[i] + OW'(push && in_cc_id == CC_ID_BITS'(i))
                                - OW'(pop && cc_mem_q[rd_ptr_q] == CC_ID_BITS'(i));
            cnt_sum  = cnt_sum + cnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < NCC; i++) cnt_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            for (int i = 0; i < NCC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q] <= in_pc;
            cc_mem_q[wr_ptr_q] <= in_cc_id;
        end
    end

    a_cnt_sum: assert property (@(posedge clk) disable iff (rst) cnt_sum == occ_q);
endmodule

// File: doc/pc_thread_fifo.md
Name: pc_thread_fifo

Overview:
Buffers (pc, cc_id) thread tokens between the output_pc handshake of one regex_cpu and the input_pc handshake of the next consumer, which is either the same or another regex_cpu. It is a show-ahead circular FIFO with registered storage. It also tracks per-cc_id occupancy, so the character-window controller knows when no live thread remains for a given character slot.

Parameters:
PC_WIDTH, 9, width of program counter
CC_ID_BITS, 2, width of character-slot id; 2**CC_ID_BITS slots
DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_pc_valid  in  1  producer offers a token
in_pc  in  PC_WIDTH  pc of offered token
in_cc_id  in  CC_ID_BITS  cc_id of offered token
in_pc_ready  out  1  FIFO can accept a token
out_pc_valid  out  1  head token available
out_pc  out  PC_WIDTH  head pc
out_cc_id  out  CC_ID_BITS  head cc_id
out_pc_ready  in  1  consumer takes head token
cc_id_empty  out  2**CC_ID_BITS  bit i = no token with cc_id i stored
occupancy  out  $clog2(DEPTH+1)  number of stored tokens
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0

Behaviour:
- Single clock domain on clk. rst is asynchronous and active-high.
- Reset values:
  - read/write pointers = 0, occupancy = 0, all per-cc_id counters = 0.
  - Hence empty = 1, full = 0, in_pc_ready = 1, out_pc_valid = 0, cc_id_empty = all ones.
  - out_pc and out_cc_id = 0.
  - Storage contents are not reset.
- Push = in_pc_valid & in_pc_ready. Pop = out_pc_valid & out_pc_ready. Both are evaluated at the rising edge.
- in_pc_ready = !full. It is purely registered-state derived, with no combinational path from out_pc_ready: when full, a simultaneous pop does not enable a push in the same cycle.
- out_pc_valid = !empty. out_pc and out_cc_id are driven from the storage entry at the read pointer, show-ahead. When empty they must read 0 (gated).
- Latency: a token pushed at edge N is visible on out_* with out_pc_valid = 1 after edge N (1 cycle). There is no bypass when empty.
- Ordering is strict FIFO across all cc_ids.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- occupancy update per edge:
  - +1 on push only, -1 on pop only, unchanged on push and pop together.
  - Push and pop together is legal in every non-full, non-empty state.
- Per-cc_id counters (width $clog2(DEPTH+1)):
  - counter[in_cc_id] += 1 on push; counter[out_cc_id] -= 1 on pop.
  - If push and pop carry the same cc_id, that counter is unchanged.
  - cc_id_empty[i] = (counter[i] == 0), registered-state derived.
- Payload and occupancy stay stable while out_pc_valid = 1 and out_pc_ready = 0.
- in_pc_valid while full: token not accepted. The producer must hold it, per the valid/ready rule.
- Reset asserted mid-operation: all state clears immediately (asynchronous). All buffered tokens are discarded. Outputs take their reset values without waiting for a clock edge.
- Invariant, checked by assertion in simulation: sum of per-cc_id counters == occupancy at every edge.

Test Plan:
- Reset, then idle 10 cycles -> in_pc_ready = 1, out_pc_valid = 0, empty = 1, cc_id_empty = 4'b1111, occupancy = 0 throughout.
- Push pc = 0x062, cc_id = 2 at edge N, out_pc_ready = 0 -> after edge N: out_pc_valid = 1, out_pc = 0x062, out_cc_id = 2, cc_id_empty = 4'b1011, occupancy = 1. Values hold for 5 cycles. Pop -> empty = 1, cc_id_empty = 4'b1111.
- Push 16 tokens, pc = 0x100..0x10F, cc_id = pc[1:0] -> full = 1, in_pc_ready = 0. A 17th offer (0x1FF) is not accepted. Pop all 16 -> pcs emerge in order 0x100..0x10F with matching cc_ids, and counters reach zero in order.
- With occupancy = 8, push and pop simultaneously for 40 cycles (pcs 0x000..0x027) -> occupancy stays 8, pointers wrap at least twice, and output order is preserved. A same-cc_id push/pop leaves that cc_id_empty bit unchanged.
- Full FIFO, out_pc_ready = 1 and in_pc_valid = 1 in the same cycle -> exactly one pop and no push. Occupancy = 15; the next cycle in_pc_ready = 1.
- Fill with 5 tokens, assert rst between clock edges -> out_pc_valid drops to 0 and cc_id_empty = 4'b1111 before the next edge. After release, a fresh push of 0x0AB appears alone at the head.
